// File: rtl/mdr_pkg.sv
// Shared types for the MDR operation dispatcher: opcodes, response error codes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdr_pkg;

    localparam int MDR_DW = 16;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIV  = 2'b01,
        OP_SQRT = 2'b10,
        OP_ILL  = 2'b11
    } mdr_op_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_DIV0    = 2'b01,
        ERR_ILLEGAL = 2'b10,
        ERR_TIMEOUT = 2'b11
    } mdr_err_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } mdr_state_e;

endpackage

// File: rtl/mdr_edge_det.sv
// Falling-edge detector: remembers last cycle's level and flags a 1->0 transition.
// Latency: fall asserts combinationally in the first cycle the input is sampled low.
// Backpressure: none; history register updates every cycle regardless of consumer.
module mdr_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic fall
);

    logic prev_q;

    // Previous-cycle sample of the input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= din;
        end
    end

    assign fall = prev_q & ~din;

endmodule

// File: rtl/mdr_op_dispatcher.sv
// Dispatcher between a host request/response port and a multi-cycle MDR core.
// Latency: accept T -> core_start T+2; error response T+2; ok response 1 cycle after core_ready falls.
// Backpressure: one transaction in flight; req_ready only in IDLE, response held until rsp_ready.
module mdr_op_dispatcher
    import mdr_pkg::*;
#(
    parameter int DW      = MDR_DW,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [DW-1:0] req_a,
    input  logic [DW-1:0] req_b,
    output logic          core_start,
    output logic [1:0]    core_op,
    output logic [DW-1:0] core_a,
    output logic [DW-1:0] core_b,
    input  logic          core_ready,
    input  logic [DW-1:0] core_q,
    input  logic [DW-1:0] core_r,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_q,
    output logic [DW-1:0] rsp_r,
    output logic [1:0]    rsp_err,
    output logic          busy
);

    // Counter only needs to reach TIMEOUT-1; keep at least one bit for tiny TIMEOUT values.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    mdr_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q;
    mdr_err_e      err_q;
    logic [DW-1:0] rsp_q_q, rsp_r_q;

    logic          core_fall;
    logic          accept;
    logic          chk_fail;
    mdr_err_e      chk_err;
    logic          capture;
    logic          abort;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          timeout_hit;

    mdr_edge_det u_edge_det (
        .clk  (clk),
        .rst  (rst),
        .din  (core_ready),
        .fall (core_fall)
    );

    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        core_start = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        chk_fail   = 1'b0;
        chk_err    = ERR_OK;
        capture    = 1'b0;
        abort      = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (core_op == OP_ILL) begin
                    chk_fail = 1'b1;
                    chk_err  = ERR_ILLEGAL;
                    state_d  = ST_RESP;
                end else if (core_op == OP_DIV && core_b == '0) begin
                    chk_fail = 1'b1;
                    chk_err  = ERR_DIV0;
                    state_d  = ST_RESP;
                end else begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                core_start = 1'b1;
                cnt_clr    = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion on the final count still counts as a good result.
                if (core_fall) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request operands are captured on acceptance and held for the core.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_op <= 2'b00;
            core_a  <= '0;
            core_b  <= '0;
        end else if (accept) begin
            core_op <= req_op;
            core_a  <= req_a;
            core_b  <= req_b;
        end
    end

    // WAIT-cycle counter; stops advancing once the abort decision is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (cnt_inc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Response words and status; only written on leaving CHECK or WAIT so RESP holds them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_q_q <= '0;
            rsp_r_q <= '0;
            err_q   <= ERR_OK;
        end else if (chk_fail) begin
            rsp_q_q <= '0;
            rsp_r_q <= '0;
            err_q   <= chk_err;
        end else if (capture) begin
            rsp_q_q <= core_q;
            rsp_r_q <= core_r;
            err_q   <= ERR_OK;
        end else if (abort) begin
            rsp_q_q <= '0;
            rsp_r_q <= '0;
            err_q   <= ERR_TIMEOUT;
        end
    end

    assign rsp_q   = rsp_q_q;
    assign rsp_r   = rsp_r_q;
    assign rsp_err = err_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: doc/mdr_op_dispatcher.md
MDR_OP_DISPATCHER -- requirements
Module: mdr_op_dispatcher

Interface
REQ-001 Parameter DW, default 16, operand/result width in bits.
REQ-002 Parameter TIMEOUT, default 64, max WAIT cycles before abort.
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  host request present.
REQ-006 req_ready  out  1  dispatcher accepts request this cycle.
REQ-007 req_op  in  2  operation: 00 MUL, 01 DIV, 10 SQRT, 11 illegal.
REQ-008 req_a, req_b  in  DW each  operands; req_b ignored for SQRT.
REQ-009 core_start  out  1  one-cycle launch pulse to MDR core.
REQ-010 core_op  out  2  registered opcode to core.
REQ-011 core_a, core_b  out  DW each  registered operands to core.
REQ-012 core_ready  in  1  core done indication, multi-cycle high; results stable once it falls.
REQ-013 core_q, core_r  in  DW each  core quotient/root/product-low, remainder/product-high.
REQ-014 rsp_valid  out  1  response present.
REQ-015 rsp_ready  in  1  host consumes response.
REQ-016 rsp_q, rsp_r  out  DW each  result words.
REQ-017 rsp_err  out  2  00 ok, 01 divide-by-zero, 10 illegal op, 11 timeout.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, CHECK, LAUNCH, WAIT, RESP.
REQ-020 IDLE: req_ready=1; req_valid&req_ready latches op/a/b into core_op/core_a/core_b, next CHECK.
REQ-021 CHECK: op=11 -> rsp_err=10, rsp_q=rsp_r=0, next RESP; op=01 with b=0 -> rsp_err=01, zero results, next RESP; otherwise next LAUNCH.
REQ-022 LAUNCH: core_start=1 for exactly this cycle, timeout counter cleared, next WAIT.
REQ-023 WAIT: a falling edge of core_ready (previous-cycle sample 1, current 0) captures core_q/core_r into rsp_q/rsp_r, rsp_err=00, next RESP.
REQ-024 core_ready SHALL be ignored outside WAIT; edge-detect register updates every cycle.
REQ-025 WAIT: counter increments each cycle; on reaching TIMEOUT-1 without a falling edge -> rsp_err=11, zero results, next RESP; falling edge on that same cycle wins (result ok).
REQ-026 RESP: rsp_valid=1, rsp_q/rsp_r/rsp_err held stable until rsp_valid&rsp_ready, then next IDLE.
REQ-027 req_ready SHALL be 0 in all states except IDLE; no back-to-back accept in RESP handshake cycle.
REQ-028 Latency: accept at cycle T -> core_start at T+2; error-path rsp_valid at T+2; ok-path rsp_valid one cycle after core_ready falls.
REQ-029 core_start SHALL never assert on error paths (illegal op, divide-by-zero).
REQ-030 Counter width SHALL be clog2(TIMEOUT); never wraps (saturates at abort).

Reset
REQ-031 rst low: state IDLE, req_ready=1 after release, core_start=0, rsp_valid=0, busy=0, all data/err registers 0, edge register 0, counter 0.
REQ-032 Reset mid-operation SHALL abandon the transaction without emitting a response.

Structure
REQ-033 Opcode enum, rsp_err enum and DW default SHALL live in shared package mdr_pkg.
REQ-034 One sub-module mdr_edge_det (registered falling-edge detector on core_ready) SHALL be instantiated.

Verification
REQ-035 SQRT a=144, core model returns q=12 r=0 after 20 cycles -> core_start at T+2, rsp_q=12, rsp_r=0, rsp_err=00.
REQ-036 DIV a=100 b=0 -> rsp_valid at T+2, rsp_err=01, core_start never high.
REQ-037 op=11 -> rsp_err=10, zero results, core_start never high.
REQ-038 Core never asserts core_ready, TIMEOUT=64 -> rsp_err=11 exactly 64 cycles after entering WAIT.
REQ-039 DIV a=100 b=7 (q=14 r=2), rsp_ready low 5 cycles -> rsp fields stable, req_ready=0, then IDLE after handshake.
REQ-040 rst asserted during WAIT -> all outputs at reset values, no rsp_valid after release until a new request.
